if_id_pipe: RTL and testbench

IF_ID_PIPE -- requirements
Module: if_id_pipe

---
 rtl/if_id_pipe_pkg.sv | 15 +
 rtl/if_id_pipe_skid_buf.sv | 43 ++++
 rtl/if_id_pipe.sv | 69 ++++++
 tb/tb_if_id_pipe.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/if_id_pipe_pkg.sv
// Shared defines for the IF/ID pipeline register: reset level, zero word, default widths.
package if_id_pipe_pkg;

  // Reset is active-low: state clears on a rising edge while rst == RST_ACTIVE.
  localparam logic RST_ACTIVE = 1'b0;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  // Wide zero constant; users cast it down to their own width.
  localparam int unsigned ZERO_W                 = 128;
  localparam logic [ZERO_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/if_id_pipe_skid_buf.sv
// Two-entry FIFO (skid buffer) with 1-bit wrapping pointers and occupancy count.
module pipe_skid_buf
  import if_id_pipe_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  // Pointer and count update; reset and clear both empty the buffer.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE || clr) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) r_wr_ptr <= ~r_wr_ptr;
      if (pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(push) - 2'(pop);
    end
  end

  // Entry storage; callers never push while full, in reset or during a clear.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline stage: 2-deep skid buffer with flush, zeroed empty outputs and stall counter.
module if_id_pipe
  import if_id_pipe_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [DATA_W-1:0] if_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_addr,
  output logic [DATA_W-1:0] id_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count;
  logic [ENT_W-1:0] w_head;
  logic [CNT_W-1:0] r_stall_cnt;

  // Handshakes; flush suppresses both so held and incoming entries are dropped.
  assign w_push = if_valid && if_ready && !flush;
  assign w_pop  = id_valid && id_ready && !flush;

  pipe_skid_buf #(
    .W(ENT_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .push    (w_push),
    .pop     (w_pop),
    .wr_data ({if_addr, if_data}),
    .rd_data (w_head),
    .count   (w_count)
  );

  // Ready depends only on reset and held occupancy, never on id_ready.
  assign if_ready  = (rst != RST_ACTIVE) && (w_count != 2'd2);
  assign id_valid  = (w_count != 2'd0);
  assign occupancy = w_count;

  // Head fields read as zero whenever the stage is empty.
  assign id_addr = id_valid ? w_head[ENT_W-1 -: ADDR_W] : ADDR_W'(ZERO_WORD);
  assign id_data = id_valid ? w_head[DATA_W-1:0]        : DATA_W'(ZERO_WORD);

  // Saturating count of cycles where ID holds off a valid head.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      r_stall_cnt <= CNT_W'(ZERO_WORD);
    end else if (id_valid && !id_ready && !flush && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed bench for if_id_pipe (CNT_W=4 so saturation is reachable).
module tb_if_id_pipe;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_data;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_addr;
  logic [DATA_W-1:0] id_data;
  logic              flush;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;

  if_id_pipe #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_addr   (if_addr),
    .if_data   (if_data),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_addr   (id_addr),
    .id_data   (id_data),
    .flush     (flush),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] a);
    if_valid = v;
    if_addr  = a;
    if_data  = data_of(a);
  endtask

  task automatic chk_head(input string tag, input logic [ADDR_W-1:0] a, input logic [1:0] occ);
    chk({tag, "_addr"}, 64'(id_addr), 64'(a));
    chk({tag, "_data"}, 64'(id_data), 64'(data_of(a)));
    chk({tag, "_occ"},  64'(occupancy), 64'(occ));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_occ"},   64'(occupancy), 64'd0);
    chk({tag, "_valid"}, 64'(id_valid), 64'd0);
    chk({tag, "_addr"},  64'(id_addr), 64'd0);
    chk({tag, "_data"},  64'(id_data), 64'd0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; id_ready = 1'b0;
    drive(1'b0, 32'h0);

    // Reset
    step(); step();
    chk_empty("rst");
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_ifready", 64'(if_ready), 64'd0);
    rst = 1'b1;
    step();
    chk("post_rst_ifready", 64'(if_ready), 64'd1);
    chk("post_rst_idvalid", 64'(id_valid), 64'd0);

    // Streaming at one entry per cycle
    id_ready = 1'b1;
    drive(1'b1, 32'h100); step(); chk_head("s0", 32'h100, 2'd1);
    drive(1'b1, 32'h104); step(); chk_head("s1", 32'h104, 2'd1);
    drive(1'b1, 32'h108); step(); chk_head("s2", 32'h108, 2'd1);
    drive(1'b0, 32'h0);   step(); chk_empty("s_drain");

    // Back-pressure
    id_ready = 1'b0;
    drive(1'b1, 32'h200); step(); chk_head("bp0", 32'h200, 2'd1);
    drive(1'b1, 32'h204); step(); chk_head("bp1", 32'h200, 2'd2);
    chk("bp_ifready", 64'(if_ready), 64'd0);
    drive(1'b1, 32'h208); step(); chk_head("bp2", 32'h200, 2'd2);
    chk("bp_stall", 64'(stall_cnt), 64'd2);
    drive(1'b0, 32'h0); id_ready = 1'b1;
    step(); chk_head("bp_rel0", 32'h204, 2'd1);
    step(); chk_empty("bp_rel1");
    chk("bp_stall_hold", 64'(stall_cnt), 64'd2);

    // Flush at full occupancy with a concurrent fetch
    id_ready = 1'b0;
    drive(1'b1, 32'h2F0); step();
    drive(1'b1, 32'h2F4); step(); chk_head("fl_pre", 32'h2F0, 2'd2);
    drive(1'b1, 32'h300); flush = 1'b1; step();
    chk_empty("fl_full");
    chk("fl_stall", 64'(stall_cnt), 64'd3);
    flush = 1'b0; drive(1'b0, 32'h0); step();
    chk_empty("fl_after");

    // Flush at occupancy 1 while a fetch would otherwise be accepted
    drive(1'b1, 32'h310); step(); chk_head("fl1_pre", 32'h310, 2'd1);
    drive(1'b1, 32'h314); flush = 1'b1; step();
    chk_empty("fl1");
    flush = 1'b0; drive(1'b0, 32'h0);

    // Stall counter saturation
    drive(1'b1, 32'h400); step(); drive(1'b0, 32'h0);
    chk("sat_start", 64'(stall_cnt), 64'd3);
    for (int i = 0; i < 11; i++) step();
    chk("sat_14", 64'(stall_cnt), 64'd14);
    step();
    chk("sat_15", 64'(stall_cnt), 64'd15);
    for (int i = 0; i < 8; i++) step();
    chk("sat_hold", 64'(stall_cnt), 64'd15);
    chk_head("sat_head", 32'h400, 2'd1);

    // Reset in the middle of operation
    rst = 1'b0; step(); rst = 1'b1;
    drive(1'b1, 32'h600); step();
    drive(1'b1, 32'h604); step();
    drive(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step();
    chk_head("mr_pre", 32'h600, 2'd2);
    chk("mr_pre_stall", 64'(stall_cnt), 64'd5);
    rst = 1'b0; step();
    chk_empty("mr_rst");
    chk("mr_rst_stall", 64'(stall_cnt), 64'd0);
    chk("mr_rst_ifready", 64'(if_ready), 64'd0);
    rst = 1'b1; step();
    chk("mr_post_ifready", 64'(if_ready), 64'd1);
    chk("mr_post_idvalid", 64'(id_valid), 64'd0);
    drive(1'b1, 32'h500); step(); drive(1'b0, 32'h0);
    chk_head("mr_fresh", 32'h500, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
